gain_param_ctrl: RTL and testbench

//  Front-panel controller for the effect-chain gain parameters (pre-gain into effects_pipeline, post-gain before DAC).

---
 rtl/gain_param_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_gain_param_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_param_ctrl.sv
// gain_param_ctrl: front-panel editor for the pre/post gains with debounced keys, press-and-hold
// auto-repeat, saturating arithmetic and LED bar. Optional macro GAIN_PARAM_CTRL_ACCEL_EN enables repeat acceleration.
module gain_param_ctrl #(
    parameter int CLK_MHZ      = 13,
    parameter int VAL_W        = 16,
    parameter int PRE_INIT     = 41,
    parameter int POST_INIT    = 6,
    parameter int VAL_MAX      = 1023,
    parameter int DEBOUNCE_US  = 5000,
    parameter int RPT_DELAY_US = 400000,
    parameter int RPT_US       = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_key_up_n,
    input  logic             i_key_dn_n,
    input  logic [1:0]       i_sel,
    input  logic [8:0]       i_led_src,
    output logic [VAL_W-1:0] o_pre_gain,
    output logic [VAL_W-1:0] o_post_gain,
    output logic             o_upd,
    output logic [8:0]       o_led
);

    localparam int DB_CYC  = DEBOUNCE_US * CLK_MHZ;
    localparam int DLY_CYC = RPT_DELAY_US * CLK_MHZ;
    localparam int RPT_CYC = RPT_US * CLK_MHZ;
    localparam int TMR_MAX = (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
    localparam int DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [VAL_W:0] MAX_EXT = (VAL_W+1)'(VAL_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RPT   = 3'd3,
        ST_LOCK  = 3'd4
    } state_t;

    // Widened step so an up-step from the top of the range or a down-step below zero is detected, then clamped.
    function automatic logic [VAL_W-1:0] next_gain(input logic [VAL_W-1:0] cur,
                                                   input logic             up,
                                                   input logic [VAL_W:0]   sz);
        logic [VAL_W:0]   ext;
        logic [VAL_W:0]   wide;
        logic [VAL_W-1:0] res;
        ext  = {1'b0, cur};
        wide = up ? (ext + sz) : (ext - sz);
        if (!up && (ext < sz)) begin
            res = '0;
        end else if (wide > MAX_EXT) begin
            res = MAX_EXT[VAL_W-1:0];
        end else begin
            res = wide[VAL_W-1:0];
        end
        return res;
    endfunction

    logic [1:0]       key_s1_q, key_s2_q;
    logic [1:0]       key_db_q, key_db_d;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];
    logic             up_p_s, dn_p_s;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dir_up_q, dir_up_d;
    logic [1:0]       sel_lat_q, sel_lat_d;
    logic             sel_ok_s, hold_key_s, other_key_s, step_s;
    logic [VAL_W:0]   step_sz_s;

    logic [VAL_W-1:0] pre_q, pre_d, post_q, post_d;
    logic             upd_q, upd_d;
    logic [8:0]       led_q, led_d;

    // Two-flop synchronisers for both raw key levels (bit 0 = up, bit 1 = down).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
        end else begin
            key_s1_q <= {i_key_dn_n, i_key_up_n};
            key_s2_q <= key_s1_q;
        end
    end

    // Debounce: count consecutive samples differing from the accepted level, restart on any return.
    always_comb begin
        key_db_d = key_db_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            if (key_s2_q[k] == key_db_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_W'(DB_CYC - 1)) begin
                key_db_d[k] = key_s2_q[k];
                db_cnt_d[k] = '0;
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
        end
    end

    // Debounced key level and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_q <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            key_db_q <= key_db_d;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
        end
    end

    assign up_p_s      = ~key_db_q[0];
    assign dn_p_s      = ~key_db_q[1];
    assign sel_ok_s    = (i_sel == 2'b01) || (i_sel == 2'b10);
    assign hold_key_s  = dir_up_q ? up_p_s : dn_p_s;
    assign other_key_s = dir_up_q ? dn_p_s : up_p_s;

    // Control FSM: next state, repeat timer and step request.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_up_d  = dir_up_q;
        sel_lat_d = sel_lat_q;
        step_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up_p_s ^ dn_p_s) begin
                    if (sel_ok_s) begin
                        state_d   = ST_FIRST;
                        dir_up_d  = up_p_s;
                        sel_lat_d = i_sel;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (up_p_s && dn_p_s) begin
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                step_s  = 1'b1;
                timer_d = TMR_W'(DLY_CYC - 1);
                state_d = ST_HOLD;
            end
            ST_HOLD, ST_RPT: begin
                if (other_key_s || (i_sel != sel_lat_q)) begin
                    state_d = ST_LOCK;
                end else if (!hold_key_s) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    step_s  = 1'b1;
                    timer_d = TMR_W'(RPT_CYC - 1);
                    state_d = ST_RPT;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_LOCK: begin
                if (!up_p_s && !dn_p_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, timer and latched edit context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            dir_up_q  <= 1'b0;
            sel_lat_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dir_up_q  <= dir_up_d;
            sel_lat_q <= sel_lat_d;
        end
    end

`ifdef GAIN_PARAM_CTRL_ACCEL_EN
    logic [3:0] rpt_cnt_q, rpt_cnt_d;

    // Repeat counter: the hold-expiry step is repeat 1, each later repeat increments up to 15.
    always_comb begin
        rpt_cnt_d = 4'd0;
        if (state_d != ST_RPT) begin
            rpt_cnt_d = 4'd0;
        end else if (!step_s) begin
            rpt_cnt_d = rpt_cnt_q;
        end else if (state_q != ST_RPT) begin
            rpt_cnt_d = 4'd1;
        end else if (rpt_cnt_q == 4'd15) begin
            rpt_cnt_d = rpt_cnt_q;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 4'd1;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= 4'd0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign step_sz_s = ((state_q == ST_RPT) && (rpt_cnt_q >= 4'd8)) ?
                       {{(VAL_W-2){1'b0}}, 3'd4} : {{VAL_W{1'b0}}, 1'b1};
`else
    assign step_sz_s = {{VAL_W{1'b0}}, 1'b1};
`endif

    // Gain update, step pulse and LED source selection.
    always_comb begin
        pre_d  = pre_q;
        post_d = post_q;
        upd_d  = step_s;
        if (step_s) begin
            if (sel_lat_q[1]) begin
                post_d = next_gain(post_q, dir_up_q, step_sz_s);
            end else begin
                pre_d = next_gain(pre_q, dir_up_q, step_sz_s);
            end
        end else begin
            pre_d  = pre_q;
            post_d = post_q;
        end
        case (i_sel)
            2'b01:   led_d = pre_q[8:0];
            2'b10:   led_d = post_q[8:0];
            default: led_d = i_led_src;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= VAL_W'(PRE_INIT);
            post_q <= VAL_W'(POST_INIT);
            upd_q  <= 1'b0;
            led_q  <= 9'd0;
        end else begin
            pre_q  <= pre_d;
            post_q <= post_d;
            upd_q  <= upd_d;
            led_q  <= led_d;
        end
    end

    assign o_pre_gain  = pre_q;
    assign o_post_gain = post_q;
    assign o_upd       = upd_q;
    assign o_led       = led_q;

endmodule

// File: tb/tb_gain_param_ctrl.sv
// Bench for gain_param_ctrl: directed scenarios plus random key/select traffic on two instances
// (default inits, and inits above the ceiling / near the floor) against an event-scheduled reference model.
module tb_gain_param_ctrl;

    localparam int DB   = 20;
    localparam int DLY  = 200;
    localparam int RPT  = 50;
    localparam int VMAX = 1023;
    localparam int MD_IDLE   = 0;
    localparam int MD_ACTIVE = 1;
    localparam int MD_LOCK   = 2;
`ifdef GAIN_PARAM_CTRL_ACCEL_EN
    localparam int LONG_GAIN = 41;
`else
    localparam int LONG_GAIN = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_up_n = 1'b1;
    logic        key_dn_n = 1'b1;
    logic [1:0]  sel = 2'b00;
    logic [8:0]  led_src = 9'd0;
    logic [15:0] pre_a, post_a, pre_b, post_b;
    logic        upd_a, upd_b;
    logic [8:0]  led_a, led_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int press_cyc, upd_cnt, upd_at;

    // reference model state
    int   m_gain [2][2];
    logic m_upd;
    logic [8:0] m_led [2];
    int   m_mode, m_first_at, m_next_at, m_reps;
    logic m_dir_up;
    logic [1:0] m_sel;
    logic m_lvl [2];
    logic hist [2][DB+2];

    always #5 clk = ~clk;

    gain_param_ctrl #(.CLK_MHZ(1), .DEBOUNCE_US(DB), .RPT_DELAY_US(DLY), .RPT_US(RPT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_key_up_n(key_up_n), .i_key_dn_n(key_dn_n), .i_sel(sel),
        .i_led_src(led_src), .o_pre_gain(pre_a), .o_post_gain(post_a), .o_upd(upd_a), .o_led(led_a));

    gain_param_ctrl #(.CLK_MHZ(1), .DEBOUNCE_US(DB), .RPT_DELAY_US(DLY), .RPT_US(RPT),
                      .PRE_INIT(1030), .POST_INIT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_key_up_n(key_up_n), .i_key_dn_n(key_dn_n), .i_sel(sel),
        .i_led_src(led_src), .o_pre_gain(pre_b), .o_post_gain(post_b), .o_upd(upd_b), .o_led(led_b));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int apply_step(input int v, input logic up, input int sz);
        int r;
        r = up ? v + sz : v - sz;
        if (r < 0) r = 0;
        if (r > VMAX) r = VMAX;
        return r;
    endfunction

    task automatic model_reset();
        m_gain[0][0] = 41;   m_gain[0][1] = 6;
        m_gain[1][0] = 1030; m_gain[1][1] = 2;
        m_upd = 1'b0;
        m_led[0] = 9'd0; m_led[1] = 9'd0;
        m_mode = MD_IDLE;
        m_reps = 0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1'b1;
            for (int i = 0; i < DB + 2; i++) hist[k][i] = 1'b1;
        end
    endtask

    // One clock edge of the reference: decisions use the debounced state from before this edge.
    task automatic model_edge();
        logic up_p, dn_p, held, other, step_now, all_same;
        logic [1:0] raw;
        int sz;
        cyc++;
        up_p = !m_lvl[0];
        dn_p = !m_lvl[1];
        step_now = 1'b0;
        sz = 1;
        for (int k = 0; k < 2; k++)
            m_led[k] = (sel == 2'b01) ? 9'(m_gain[k][0]) : (sel == 2'b10) ? 9'(m_gain[k][1]) : led_src;
        if (m_mode == MD_IDLE) begin
            if ((up_p ^ dn_p) && (sel == 2'b01 || sel == 2'b10)) begin
                m_mode = MD_ACTIVE;
                m_dir_up = up_p;
                m_sel = sel;
                m_first_at = cyc + 1;
                m_next_at = cyc + 1 + DLY;
                m_reps = 0;
            end else if (up_p || dn_p) begin
                m_mode = MD_LOCK;
            end
        end else if (m_mode == MD_ACTIVE) begin
            held  = m_dir_up ? up_p : dn_p;
            other = m_dir_up ? dn_p : up_p;
            if (cyc == m_first_at) begin
                step_now = 1'b1;
            end else if (other || sel != m_sel) begin
                m_mode = MD_LOCK;
            end else if (!held) begin
                m_mode = MD_IDLE;
            end else if (cyc == m_next_at) begin
                step_now = 1'b1;
                m_reps++;
                m_next_at = cyc + RPT;
`ifdef GAIN_PARAM_CTRL_ACCEL_EN
                if (m_reps > 8) sz = 4;
`endif
            end
        end else begin
            if (!up_p && !dn_p) m_mode = MD_IDLE;
        end
        if (step_now)
            for (int k = 0; k < 2; k++)
                m_gain[k][m_sel[1]] = apply_step(m_gain[k][m_sel[1]], m_dir_up, sz);
        m_upd = step_now;
        raw = {key_dn_n, key_up_n};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DB + 1; i++) hist[k][i] = hist[k][i+1];
            hist[k][DB+1] = raw[k];
            all_same = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[k][i] != hist[k][0]) all_same = 1'b0;
            if (all_same) m_lvl[k] = hist[k][0];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("pre_a",  pre_a,  m_gain[0][0]);
        check_val("post_a", post_a, m_gain[0][1]);
        check_val("pre_b",  pre_b,  m_gain[1][0]);
        check_val("post_b", post_b, m_gain[1][1]);
        check_val("upd_a",  upd_a,  m_upd);
        check_val("upd_b",  upd_b,  m_upd);
        check_val("led_a",  led_a,  m_led[0]);
        check_val("led_b",  led_b,  m_led[1]);
        if (upd_a) begin
            upd_cnt++;
            upd_at = cyc;
        end
        @(negedge clk);
        led_src = 9'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input logic up, input int n);
        if (up) key_up_n = 1'b0;
        else    key_dn_n = 1'b0;
        press_cyc = cyc + 1;
        idle(n);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_val("rst_pre_a", pre_a, 41);
        check_val("rst_post_a", post_a, 6);
        check_val("rst_upd_a", upd_a, 0);
        check_val("rst_led_a", led_a, 0);
        check_val("rst_pre_b", pre_b, 1030);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // single press, latency and untouched post gain
        sel = 2'b01; upd_cnt = 0; upd_at = -1000;
        press(1'b1, 100); idle(50);
        check_val("press_latency", upd_at - press_cyc, DB + 3);
        check_val("press_upd_cnt", upd_cnt, 1);
        check_val("press_pre_a", pre_a, 42);
        check_val("press_post_a", post_a, 6);
        check_val("press_pre_b", pre_b, 1023);

        // bounce shorter than the debounce window
        upd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            key_dn_n = 1'b0; idle(10);
            key_dn_n = 1'b1; idle(5);
        end
        idle(50);
        check_val("bounce_upd_cnt", upd_cnt, 0);
        check_val("bounce_pre_a", pre_a, 42);

        // hold with auto-repeat
        sel = 2'b10; upd_cnt = 0;
        press(1'b1, 500); idle(50);
        check_val("hold_upd_cnt", upd_cnt, 7);
        check_val("hold_post_a", post_a, 13);
        check_val("hold_post_b", post_b, 9);

        // ceiling saturation still pulses o_upd
        sel = 2'b01; upd_cnt = 0;
        press(1'b1, 400); idle(50);
        check_val("sat_upd_cnt", upd_cnt, 5);
        check_val("sat_pre_b", pre_b, 1023);
        check_val("sat_pre_a", pre_a, 47);

        // floor saturation
        sel = 2'b10; upd_cnt = 0;
        press(1'b0, 600); idle(50);
        check_val("floor_upd_cnt", upd_cnt, 9);
        check_val("floor_post_b", post_b, 0);
        check_val("floor_post_a", post_a, 4);

        // both keys together, then release one at a time
        sel = 2'b01; upd_cnt = 0;
        key_up_n = 1'b0; key_dn_n = 1'b0; idle(100);
        key_up_n = 1'b1; idle(300);
        key_dn_n = 1'b1; idle(50);
        check_val("both_upd_cnt", upd_cnt, 0);
        check_val("both_pre_a", pre_a, 47);

        // select change during repeat locks, later press edits post only
        sel = 2'b01; upd_cnt = 0;
        key_up_n = 1'b0; idle(300);
        sel = 2'b10; idle(100);
        key_up_n = 1'b1; idle(50);
        check_val("selchg_upd_cnt", upd_cnt, 3);
        check_val("selchg_pre_a", pre_a, 50);
        press(1'b1, 100); idle(50);
        check_val("selchg_post_a", post_a, 5);
        check_val("selchg_pre_a2", pre_a, 50);

        // long hold (accelerated steps when enabled)
        upd_cnt = 0;
        press(1'b1, 1000); idle(50);
        check_val("long_upd_cnt", upd_cnt, 17);
        check_val("long_post_a", post_a, 5 + LONG_GAIN);
        check_val("long_post_b", post_b, 1 + LONG_GAIN);

        // asynchronous reset in the middle of a hold
        sel = 2'b01;
        key_up_n = 1'b0; idle(250);
        key_up_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_pre_a", pre_a, 41);
        check_val("midrst_post_a", post_a, 6);
        check_val("midrst_upd_a", upd_a, 0);
        check_val("midrst_led_a", led_a, 0);
        check_val("midrst_pre_b", pre_b, 1030);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        upd_cnt = 0;
        idle(60);
        check_val("midrst_upd_cnt", upd_cnt, 0);
        check_val("midrst_pre_a2", pre_a, 41);

        // random traffic
        for (int s = 0; s < 40; s++) begin
            int len;
            len = $urandom_range(5, 350);
            sel = 2'($urandom_range(0, 3));
            key_up_n = 1'($urandom_range(0, 1));
            key_dn_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 99) == 0)  sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 149) == 0) key_up_n = ~key_up_n;
                if ($urandom_range(0, 199) == 0) key_dn_n = ~key_dn_n;
                cycle();
            end
        end
        key_up_n = 1'b1; key_dn_n = 1'b1;
        idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
